// File: rtl/nixie_display_arbiter_pkg.sv
// Shared constants for the nixie display arbiter: segment codes and FSM states.
// Segment bit order is {dp,g,f,e,d,c,b,a}, active high.
package nixie_display_arbiter_pkg;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/nixie_display_arbiter_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; codes 10..15 show a dash, dp always off.
module bcd_to_seg7
    import nixie_display_arbiter_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/nixie_display_arbiter.sv
// Round-robin arbiter sharing a two-digit 7-segment display with a minimum slot length.
// Define LEADING_ZERO_BLANK_EN to blank a high digit of 0.
module nixie_display_arbiter
    import nixie_display_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter logic [15:0] HOLD_CYCLES = 16'd50000
) (
    input  logic                   Sys_CLK,
    input  logic                   Sys_RST_N,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   bcd_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             SEG_H,
    output logic [7:0]             SEG_L,
    output logic                   en,
    output state_e                 dbg_state_o
);

    localparam int unsigned PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
    localparam logic [15:0]   HOLD_END = HOLD_CYCLES - 16'd1;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]        last_ptr_q, last_ptr_d;
    logic [15:0]          hold_cnt_q, hold_cnt_d;
    logic [7:0]           seg_h_q, seg_h_d;
    logic [7:0]           seg_l_q, seg_l_d;
    logic                 en_q;

    logic [NUM_REQ-1:0]   pend;
    logic                 found;
    logic [PW-1:0]        found_idx;
    logic [7:0]           sel_byte;
    logic [7:0]           dec_h;
    logic [7:0]           dec_l;

    // Masking out the current grantee makes one search serve both IDLE (grant is 0)
    // and slot expiry (only other requesters may take over).
    assign pend = req & ~grant_q;

    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            int c;
            c = (int'(last_ptr_q) + k) % int'(NUM_REQ);
            if (!found && pend[c]) begin
                found     = 1'b1;
                found_idx = PW'(c);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_ptr_d = last_ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (found) begin
                    grant_d[found_idx] = 1'b1;
                    state_d            = ST_HOLD;
                    last_ptr_d         = found_idx;
                    hold_cnt_d         = '0;
                end
            end
            ST_HOLD: begin
                if (!req[last_ptr_q]) begin
                    grant_d    = '0;
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_END) begin
                    hold_cnt_d = '0;
                    if (found) begin
                        grant_d            = '0;
                        grant_d[found_idx] = 1'b1;
                        last_ptr_d         = found_idx;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q[i]) sel_byte = sel_byte | bcd_data[8*i +: 8];
        end
    end

    bcd_to_seg7 u_dec_h (.bcd_i(sel_byte[7:4]), .seg_o(dec_h));
    bcd_to_seg7 u_dec_l (.bcd_i(sel_byte[3:0]), .seg_o(dec_l));

    always_comb begin
        seg_h_d = SEG_BLANK;
        seg_l_d = SEG_BLANK;
        if (|grant_q) begin
`ifdef LEADING_ZERO_BLANK_EN
            seg_h_d = (sel_byte[7:4] == 4'd0) ? SEG_BLANK : dec_h;
`else
            seg_h_d = dec_h;
`endif
            seg_l_d = dec_l;
        end
    end

    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
        if (!Sys_RST_N) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_ptr_q <= LAST_IDX;
            hold_cnt_q <= '0;
            seg_h_q    <= SEG_BLANK;
            seg_l_q    <= SEG_BLANK;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_ptr_q <= last_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            seg_h_q    <= seg_h_d;
            seg_l_q    <= seg_l_d;
            en_q       <= |grant_q;
        end
    end

    assign grant       = grant_q;
    assign SEG_H       = seg_h_q;
    assign SEG_L       = seg_l_q;
    assign en          = en_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nixie_display_arbiter.sv
// Directed bench for nixie_display_arbiter with NUM_REQ=4, HOLD_CYCLES=4.
module tb_nixie_display_arbiter;
    import nixie_display_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] bcd_data;
    logic [3:0]  grant;
    logic [7:0]  seg_h;
    logic [7:0]  seg_l;
    logic        en;
    state_e      dbg_state;

    int checks = 0;
    int errors = 0;

    nixie_display_arbiter #(
        .NUM_REQ(4),
        .HOLD_CYCLES(16'd4)
    ) dut (
        .Sys_CLK    (clk),
        .Sys_RST_N  (rst_n),
        .req        (req),
        .bcd_data   (bcd_data),
        .grant      (grant),
        .SEG_H      (seg_h),
        .SEG_L      (seg_l),
        .en         (en),
        .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] rot_exp [4];
    logic [7:0] lz_exp;

    initial begin
        rot_exp[0] = 4'b0010;
        rot_exp[1] = 4'b1000;
        rot_exp[2] = 4'b0001;
        rot_exp[3] = 4'b0010;
`ifdef LEADING_ZERO_BLANK_EN
        lz_exp = 8'h00;
`else
        lz_exp = 8'h3F;
`endif

        rst_n    = 1'b0;
        req      = 4'b0000;
        bcd_data = 32'h0;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_en", 32'(en), 32'h0);
        check("rst_seg_h", 32'(seg_h), 32'h00);
        check("rst_seg_l", 32'(seg_l), 32'h00);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick();
        check("idle_no_req", 32'(grant), 32'h0);

        // Single requester 0 showing 42
        req           = 4'b0001;
        bcd_data[7:0] = 8'h42;
        tick();
        check("single_grant", 32'(grant), 32'h1);
        check("single_en_lat", 32'(en), 32'h0);
        check("single_seg_lat", 32'(seg_h), 32'h00);
        tick();
        check("single_seg_h", 32'(seg_h), 32'h66);
        check("single_seg_l", 32'(seg_l), 32'h5B);
        check("single_en", 32'(en), 32'h1);
        for (int i = 0; i < 9; i++) tick();
        check("single_held", 32'(grant), 32'h1);
        check("single_state", 32'(dbg_state), 32'(ST_HOLD));

        bcd_data[7:0] = 8'hA3;
        tick();
        check("inv_seg_h", 32'(seg_h), 32'h40);
        check("inv_seg_l", 32'(seg_l), 32'h4F);

        bcd_data[7:0] = 8'h07;
        tick();
        check("lz_seg_h", 32'(seg_h), 32'(lz_exp));
        check("lz_seg_l", 32'(seg_l), 32'h07);

        req = 4'b0000;
        tick();
        check("drop_grant", 32'(grant), 32'h0);
        check("drop_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        check("drop_en", 32'(en), 32'h0);
        check("drop_seg_h", 32'(seg_h), 32'h00);

        // Rotation with last grantee 0: order 1,3,0,1, four cycles each
        bcd_data = 32'h5600_3412;
        req      = 4'b1011;
        for (int i = 0; i < 13; i++) begin
            tick();
            check($sformatf("rot_%0d", i), 32'(grant), 32'(rot_exp[i/4]));
        end
        tick();
        check("early_pre", 32'(grant), 32'h2);
        check("rot_seg_h", 32'(seg_h), 32'h4F);
        req = 4'b1001;
        tick();
        check("early_gap", 32'(grant), 32'h0);
        check("early_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        check("early_next", 32'(grant), 32'h8);
        check("early_gap_en", 32'(en), 32'h0);
        tick();
        check("r3_seg_h", 32'(seg_h), 32'h6D);
        check("r3_seg_l", 32'(seg_l), 32'h7D);
        check("r3_en", 32'(en), 32'h1);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_grant", 32'(grant), 32'h0);
        check("arst_en", 32'(en), 32'h0);
        check("arst_seg_h", 32'(seg_h), 32'h00);
        check("arst_seg_l", 32'(seg_l), 32'h00);
        req      = 4'b0100;
        bcd_data = 32'h0089_0000;
        tick();
        check("arst_held", 32'(grant), 32'h0);
        rst_n = 1'b1;
        tick();
        check("rel_grant", 32'(grant), 32'h4);
        tick();
        check("rel_seg_h", 32'(seg_h), 32'h7F);
        check("rel_seg_l", 32'(seg_l), 32'h6F);
        bcd_data[23:16] = 8'h90;
        tick();
        check("track_seg_h", 32'(seg_h), 32'h6F);
        check("track_seg_l", 32'(seg_l), 32'h3F);
        check("track_grant", 32'(grant), 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nixie_display_arbiter.md
Name: nixie_display_arbiter

Overview:
- Shares the two-digit multiplexed 7-segment display between NUM_REQ requesters, e.g. clock, counter and error-code blocks.
- Each requester offers two BCD digits plus a request line. The block grants one requester at a time, round-robin, with a minimum hold time.
- It decodes the granted digits and drives the display driver's SEG_H, SEG_L and en inputs directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 16'd50000, minimum grant slot length in Sys_CLK cycles (1 ms at 50 MHz); must be at least 2.

Ports:
- Sys_CLK  input  1  system clock, 50 MHz.
- Sys_RST_N  input  1  reset; one clock, reset asynchronous and active-low.
- req  input  NUM_REQ  request per requester; a requester holds it high while it wants the display.
- bcd_data  input  NUM_REQ*8  requester i owns bits [8i+7:8i]; [8i+7:8i+4] is the high digit, [8i+3:8i] is the low digit.
- grant  output  NUM_REQ  one-hot grant, or all zero when no requester holds the display.
- SEG_H  output  8  decoded high digit, bit order {dp,g,f,e,d,c,b,a}, active high.
- SEG_L  output  8  decoded low digit, same bit order.
- en  output  1  display enable.

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, SEG_H=SEG_L=8'h00, en=0, hold_cnt=0, last_ptr=NUM_REQ-1.
- Round-robin search starts at index last_ptr+1 modulo NUM_REQ.
- IDLE state:
  - If any req is high at edge k, grant goes one-hot to the first requester in search order at edge k.
  - State becomes HOLD, last_ptr is set to the granted index, hold_cnt=0.
- HOLD state:
  - hold_cnt increments each cycle.
  - If the grantee's req is low at an edge: grant=0 and state=IDLE at that edge. Re-arbitration happens no earlier than the next edge, so there is a 1-cycle gap. This case has priority over expiry.
  - If hold_cnt==HOLD_CYCLES-1 and another requester is pending: grant moves directly to the next requester in search order at that edge, with no gap. hold_cnt=0 and last_ptr is updated.
  - If hold_cnt==HOLD_CYCLES-1 and no other requester is pending: grant is kept and hold_cnt wraps to 0.
- A request from another requester never pre-empts a slot before expiry.
- Output path (registered, 1-cycle latency after grant):
  - SEG_H and SEG_L are the decoded bcd_data of the requester granted during the previous cycle.
  - en = |grant from the previous cycle.
  - When grant was 0, SEG_H=SEG_L=8'h00.
  - Data changes while granted are tracked with the same 1-cycle latency.
- Decode values:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - Invalid BCD 10..15 → 8'h40 ('-').
  - dp is always 0.
- Reset asserted mid-slot: all outputs clear immediately (asynchronously); after release arbitration restarts from index 0.
- Invariant: grant is never more than one-hot.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when the granted high digit is 0, SEG_H=8'h00 (blank). The low digit is unaffected.
- Not defined: a high digit of 0 displays 8'h3F.
- In both cases the value latency is unchanged.

Decomposition:
- Shared package holds:
  - SEG_* localparams for the ten digit codes.
  - SEG_DASH=8'h40 and SEG_BLANK=8'h00.
  - IDLE/HOLD state encodings.
- Sub-module: bcd_to_seg7, a combinational 4-bit to 8-bit decoder, instantiated twice.
- The round-robin search stays inline.

Test Plan (NUM_REQ=4, HOLD_CYCLES=4):
- Reset mid-grant: assert Sys_RST_N=0 between edges → grant=0, en=0, SEG_H=SEG_L=00 immediately. Release with req=4'b0100 → grant=0100 at the first edge.
- Single requester: req=0001 with bcd_data[7:0]=8'h42 → grant=0001 at edge 1. SEG_H=66 and SEG_L=5B at edge 2, en=1 at edge 2. Grant is held indefinitely while req is held.
- Rotation: req=1011 held → grant sequence 0001, 0010, 1000, 0001…. Each slot lasts exactly 4 cycles with no gaps.
- Early release: grantee 0010 drops req 2 cycles into its slot while req[3]=1 → grant=0 for 1 cycle, then grant=1000.
- Invalid BCD: bcd_data=8'hA3 on the grantee → SEG_H=40, SEG_L=4F.
- Leading zero: bcd_data=8'h07 → SEG_H=00 with LEADING_ZERO_BLANK_EN defined, 3F without. SEG_L=07 in both cases.
